// File: rtl/geofence_host.sv
// Stimulus/checker master for the geofence point-in-hexagon engine: stores up
// to 16 cases, streams each case's 7 points to the engine and scores verdicts.
module geofence_host #(
  parameter int unsigned NUM_CASES = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [19:0] cfg_data,
  input  logic        start,
  output logic        geo_reset,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  input  logic        valid,
  input  logic        is_inside,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [4:0]  err_cnt,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  localparam logic [3:0] LAST_CASE = 4'(NUM_CASES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [19:0] pts [16][7];
  logic [15:0] exp_vec;

  state_t      state;
  logic [3:0]  case_idx;
  logic [2:0]  pt;
  logic [7:0]  wcnt;
  logic [19:0] send_pt;
  logic [19:0] next_obj;
  logic [19:0] first_obj;

  // Case storage survives reset; only the config port ever writes it.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      if (cfg_addr[2:0] == 3'd7)
        exp_vec[cfg_addr[6:3]] <= cfg_data[0];
      else
        pts[cfg_addr[6:3]][cfg_addr[2:0]] <= cfg_data;
    end
  end

  always_comb begin
    send_pt   = '0;
    if (pt != 3'd6)
      send_pt = pts[case_idx][3'(pt + 3'd1)];
    next_obj  = pts[4'(case_idx + 4'd1)][0];
    first_obj = pts[0][0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      case_idx  <= '0;
      pt        <= '0;
      wcnt      <= '0;
      geo_reset <= 1'b1;
      X         <= '0;
      Y         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      err_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            case_idx  <= '0;
            pt        <= '0;
            {X, Y}    <= first_obj;
            geo_reset <= 1'b0;
            result    <= '0;
            err_cnt   <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (pt == 3'd6) begin
            {X, Y} <= '0;
            wcnt   <= '0;
            state  <= WAIT;
          end else begin
            {X, Y} <= send_pt;
            pt     <= 3'(pt + 3'd1);
          end
        end
        WAIT: begin
          // A valid on the final timeout cycle still counts as a result.
          if (valid) begin
            result[case_idx] <= is_inside;
            if (is_inside != exp_vec[case_idx] && err_cnt != 5'd31)
              err_cnt <= 5'(err_cnt + 5'd1);
            if (case_idx == LAST_CASE) begin
              geo_reset <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              case_idx <= 4'(case_idx + 4'd1);
              pt       <= '0;
              {X, Y}   <= next_obj;
              state    <= SEND;
            end
          end else if (wcnt == WAIT_LAST) begin
            timeout   <= 1'b1;
            geo_reset <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            wcnt <= 8'(wcnt + 8'd1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/geofence_host.md
# geofence_host

Stimulus/checker master for the `geofence` point-in-hexagon engine. It sits on the driving side of the engine's X/Y/valid/is_inside interface. It stores up to 16 test cases, each with one object point, six fence vertices and an expected verdict, loaded over a simple config write port. On `start` it releases the engine from reset and streams each case one point per cycle, then waits for the engine's one-cycle `valid` pulse. It captures `is_inside`, compares it with the expected verdict, and reports per-case results, an error count and a timeout flag.

## Interface
- NUM_CASES, 8, number of cases run per `start` (legal 1..16)
- TIMEOUT, 64, max cycles spent in WAIT for `valid` before aborting (legal 8..255)
- clk  input  1  single clock, all registers on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- cfg_we  input  1  config write strobe; ignored while `busy`=1
- cfg_addr  input  7  {case[3:0], idx[2:0]}; idx 0 = object, 1..6 = fence vertices G1..G6, 7 = expected verdict
- cfg_data  input  20  {X[9:0], Y[9:0]} for idx 0..6; bit 0 = expected `is_inside` for idx 7
- start  input  1  one-cycle pulse; begins a run when `busy`=0
- geo_reset  output  1  reset to engine, registered; 1 whenever not running
- X, Y  output  10 each  point bus to engine, registered
- valid  input  1  engine result strobe (one-cycle pulse)
- is_inside  input  1  engine verdict, qualified by `valid`
- busy  output  1  high from accepted `start` until DONE exits
- done  output  1  one-cycle pulse at end of run
- result  output  16  bit k = captured `is_inside` of case k; bits ≥ NUM_CASES stay 0
- err_cnt  output  5  number of cases whose verdict ≠ expected
- timeout  output  1  sticky until next `start`; set on WAIT expiry

## Operation
- Storage: 16×7×20-bit point array plus 16-bit expected vector. Writes take effect at the clock edge and are never cleared by reset; contents are undefined until written.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE: geo_reset=1, X=Y=0. When start=1, the edge sets case=0, pt=0, X/Y←point[0][0], geo_reset←0, clears result/err_cnt/timeout, busy←1, and moves to SEND.
- SEND: each edge drives X/Y←point[case][pt+1] and increments pt. The edge at pt=6 zeroes X/Y, clears the wait counter and moves to WAIT. Exactly 7 consecutive points go out per case, in order Obj, G1..G6.
- WAIT: the wait counter increments each cycle. On an edge with valid=1:
  - result[case]←is_inside; err_cnt increments if is_inside ≠ expected[case].
  - If case = NUM_CASES−1, geo_reset←1 and the FSM moves to DONE.
  - Otherwise case increments, pt=0, X/Y←point[case+1][0] on that same edge, and the FSM moves to SEND.
- WAIT timeout: if the counter reaches TIMEOUT−1 with no valid, timeout←1, geo_reset←1, and the FSM moves to DONE. The remaining cases are not run.
- DONE: done=1 for one cycle, busy←0, then the FSM moves to IDLE.
- `valid` seen outside WAIT is ignored. `start` while busy is ignored. `cfg_we` while busy is ignored.
- err_cnt saturates at 31 (unreachable with ≤16 cases; still required).
- Reset mid-run: all outputs return to reset values immediately (asynchronous), with geo_reset=1. Stored vectors are kept.

## Timing
- Reset values: geo_reset=1, X=0, Y=0, busy=0, done=0, result=0, err_cnt=0, timeout=0. FSM resets to IDLE.
- Engine protocol: the engine samples one point per rising edge, starting with the first edge after geo_reset falls and with the first edge after its `valid` pulse. Hence:
  - Point 0 of the first case must be on X/Y in the same cycle geo_reset is first low.
  - Point 0 of each later case must appear in the cycle immediately after `valid` is high. There are no bubble cycles.
- Start latency: start high at edge e0 → geo_reset low and Obj on X/Y after e0; G6 on X/Y after e0+6; WAIT entered at e0+7.
- Per-case occupancy = 7 + (cycles until valid). With the engine this is about 25–30 cycles.
- Outputs change only on clock edges (plus asynchronous reset). `result`/`err_cnt` are stable from `done` until the next accepted `start`.

## Test plan
- Single case, NUM_CASES=1, fence (100,0),(200,0),(300,100),(200,200),(100,200),(0,100) loaded in scrambled order, object (150,100), expected=1. Real engine → X/Y sequence matches the stored order exactly; result[0]=1, err_cnt=0, one done pulse, geo_reset high after done.
- Same fence, object (350,100), expected=0, followed back-to-back by the inside case (NUM_CASES=2) → case 1's Obj appears the cycle after the first valid with no gap; result=16'b10, err_cnt=0.
- Wrong expectation: 4 cases, expected bits inverted on cases 1 and 3 → err_cnt=2, result matches the engine's verdicts.
- Timeout: engine replaced by a stub that never asserts valid, TIMEOUT=16 → timeout=1 exactly 16 cycles after WAIT entry, done pulses, result=0, busy falls.
- Robustness: start pulses and cfg_we pulses during a run, plus a spurious valid during SEND → all ignored; run completes unchanged and stored data is unaltered.
- Async reset asserted mid-SEND → outputs take reset values immediately. Next start reruns case 0 from Obj using the previously loaded vectors.
